// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: opcode/state encodings and
// the single-cycle ALU/shifter evaluation function.
package exec_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int MUL_CYCLES = 16;
    localparam int MUL_CNT_W  = 5;
    localparam int SHAMT_W    = 4;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic                  carry;
    } alu_res_t;

    // Shifts use a one-bit extension so the last bit shifted out lands in the
    // extension bit; a zero shift amount leaves that bit clear.
    function automatic alu_res_t alu_single(input opcode_e op,
                                            input logic [DEF_DATA_W-1:0] a,
                                            input logic [DEF_DATA_W-1:0] b);
        alu_res_t             r;
        logic [DEF_DATA_W:0]  wide;
        logic [SHAMT_W-1:0]   sh;
        r    = '0;
        wide = '0;
        sh   = b[SHAMT_W-1:0];
        case (op)
            ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                r.result = wide[DEF_DATA_W-1:0];
                r.carry  = wide[DEF_DATA_W];
            end
            SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                r.result = wide[DEF_DATA_W-1:0];
                r.carry  = wide[DEF_DATA_W];
            end
            AND: r.result = a & b;
            OR:  r.result = a | b;
            XOR: r.result = a ^ b;
            SHL: begin
                wide     = {1'b0, a} << sh;
                r.result = wide[DEF_DATA_W-1:0];
                r.carry  = wide[DEF_DATA_W];
            end
            SHR: begin
                wide     = {a, 1'b0} >> sh;
                r.result = wide[DEF_DATA_W:1];
                r.carry  = wide[0];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_unit_mul.sv
// Radix-2 shift-add unsigned multiplier: the first partial product is taken on
// the start edge, so valid pulses MUL_CYCLES cycles after start.
module mul16_seq
    import exec_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DEF_DATA_W-1:0]     a,
    input  logic [DEF_DATA_W-1:0]     b,
    output logic                      busy,
    output logic [2*DEF_DATA_W-1:0]   product,
    output logic                      valid
);

    logic                    busy_q,   busy_d;
    logic                    valid_q,  valid_d;
    logic [2*DEF_DATA_W-1:0] acc_q,    acc_d;
    logic [2*DEF_DATA_W-1:0] mcand_q,  mcand_d;
    logic [DEF_DATA_W-1:0]   mplier_q, mplier_d;
    logic [MUL_CNT_W-1:0]    cnt_q,    cnt_d;

    // One multiplier bit is consumed per cycle; cnt counts bits already consumed.
    always_comb begin
        busy_d   = busy_q;
        valid_d  = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = b[0] ? {{DEF_DATA_W{1'b0}}, a} : {2*DEF_DATA_W{1'b0}};
            mcand_d  = {{(DEF_DATA_W-1){1'b0}}, a, 1'b0};
            mplier_d = {1'b0, b[DEF_DATA_W-1:1]};
            cnt_d    = MUL_CNT_W'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + MUL_CNT_W'(1);
            if (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else begin
                busy_d  = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign product = acc_q;

endmodule

// File: rtl/exec_unit.sv
// Execute stage between the 8x16 register file read ports and its write port:
// IDLE -> READ -> EXEC (1 or 16 cycles) -> WB, one instruction at a time.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs0,
    input  logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rd0_addr,
    output logic [ADDR_W-1:0] rd1_addr,
    input  logic [DATA_W-1:0] rd0_data,
    input  logic [DATA_W-1:0] rd1_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    state_e              state_q,       state_d;
    opcode_e             op_q,          op_d;
    logic [ADDR_W-1:0]   rd_q,          rd_d;
    logic [ADDR_W-1:0]   rd0_addr_q,    rd0_addr_d;
    logic [ADDR_W-1:0]   rd1_addr_q,    rd1_addr_d;
    logic [DATA_W-1:0]   a_q,           a_d;
    logic [DATA_W-1:0]   b_q,           b_d;
    logic                instr_ready_q, instr_ready_d;
    logic                wr_en_q,       wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,     wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,     wr_data_d;
    logic                done_q,        done_d;
    logic                flag_z_q,      flag_z_d;
    logic                flag_c_q,      flag_c_d;

    logic                accept_s;
    logic                mul_start_s;
    logic                mul_busy_s;
    logic                mul_valid_s;
    logic [2*DATA_W-1:0] mul_product_s;
    logic                exec_done_s;
    alu_res_t            alu_s;
    logic [DATA_W-1:0]   result_s;
    logic                carry_s;

    assign accept_s    = (state_q == IDLE) && instr_valid;
    // The multiplier takes its operands straight from the read ports during READ,
    // which is what lets the product be ready after exactly 16 EXEC cycles.
    assign mul_start_s = (state_q == READ) && (op_q == MUL) && !mul_busy_s;
    assign exec_done_s = (state_q == EXEC) && ((op_q != MUL) || mul_valid_s);

    mul16_seq u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (rd0_data),
        .b       (rd1_data),
        .busy    (mul_busy_s),
        .product (mul_product_s),
        .valid   (mul_valid_s)
    );

    assign alu_s    = alu_single(op_q, a_q, b_q);
    assign result_s = (op_q == MUL) ? mul_product_s[DATA_W-1:0] : alu_s.result;
    assign carry_s  = (op_q == MUL) ? (|mul_product_s[2*DATA_W-1:DATA_W]) : alu_s.carry;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                if (exec_done_s) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: instruction latch, operand capture and write-back values.
    always_comb begin
        op_d          = op_q;
        rd_d          = rd_q;
        rd0_addr_d    = rd0_addr_q;
        rd1_addr_d    = rd1_addr_q;
        a_d           = a_q;
        b_d           = b_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        flag_z_d      = flag_z_q;
        flag_c_d      = flag_c_q;
        wr_en_d       = 1'b0;
        done_d        = 1'b0;
        instr_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d       = opcode_e'(opcode);
                    rd_d       = rd;
                    rd0_addr_d = rs0;
                    rd1_addr_d = rs1;
                end else begin
                    op_d       = op_q;
                end
            end
            READ: begin
                a_d = rd0_data;
                b_d = rd1_data;
            end
            EXEC: begin
                if (exec_done_s) begin
                    wr_en_d   = 1'b1;
                    done_d    = 1'b1;
                    wr_addr_d = rd_q;
                    wr_data_d = result_s;
                    flag_z_d  = (result_s == {DATA_W{1'b0}});
                    flag_c_d  = carry_s;
                end else begin
                    wr_en_d   = 1'b0;
                end
            end
            WB:      wr_en_d = 1'b0;
            default: wr_en_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= ADD;
            rd_q          <= '0;
            rd0_addr_q    <= '0;
            rd1_addr_q    <= '0;
            a_q           <= '0;
            b_q           <= '0;
            instr_ready_q <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
        end else begin
            op_q          <= op_d;
            rd_q          <= rd_d;
            rd0_addr_q    <= rd0_addr_d;
            rd1_addr_q    <= rd1_addr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            instr_ready_q <= instr_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            flag_z_q      <= flag_z_d;
            flag_c_q      <= flag_c_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign rd0_addr    = rd0_addr_q;
    assign rd1_addr    = rd1_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural register file and a
// scoreboard of expected write-backs.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  opcode = 3'd0;
    logic [2:0]  rd = 3'd0, rs0 = 3'd0, rs1 = 3'd0;
    logic [2:0]  rd0_addr, rd1_addr, wr_addr;
    logic [15:0] rd0_data, rd1_data, wr_data;
    logic        wr_en, done, flag_z, flag_c;

    logic [15:0] rf [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_waddr = 3'd0;
    logic [15:0] tb_wdata = 16'h0000;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs0         (rs0),
        .rs1         (rs1),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .rd0_data    (rd0_data),
        .rd1_data    (rd1_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    assign rd0_data = rf[rd0_addr];
    assign rd1_data = rf[rd1_addr];

    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
        else if (tb_we) rf[tb_waddr] <= tb_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic c);
        int n;
        logic [31:0] p;
        n = int'(b[3:0]);
        c = 1'b0;
        case (op)
            3'd0: begin p = 32'(a) + 32'(b); r = p[15:0]; c = p[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << n; c = (n == 0) ? 1'b0 : a[16-n]; end
            3'd6: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            default: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p[31:16] != 16'h0000); end
        endcase
    endfunction

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [15:0] d, input logic c);
        exp_t e;
        e.addr = a; e.data = d; e.z = (d == 16'h0000); e.c = c;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s0,
                         input logic [2:0] s1, input logic hold);
        int guard;
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 40) begin
            @(negedge clk); guard++;
        end
        check("ready_before_issue", instr_ready, 1'b1);
        opcode = op; rd = d; rs0 = s0; rs1 = s1; instr_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        check("rd0_addr", rd0_addr, s0);
        check("rd1_addr", rd1_addr, s1);
    endtask

    task automatic wait_wb(input int exp_lat);
        int lat;
        exp_t e;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk); lat++;
            if (wr_en === 1'b1) break;
            check("busy_ready_low", instr_ready, 1'b0);
        end
        check("wb_latency", lat, exp_lat);
        check("sb_nonempty", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("done", done, 1'b1);
            check("flag_z", flag_z, e.z);
            check("flag_c", flag_c, e.c);
            @(negedge clk);
            check("wr_en_one_cycle", wr_en, 1'b0);
            check("ready_after_wb", instr_ready, 1'b1);
            check("rf_written", rf[e.addr], e.data);
        end
    endtask

    initial begin
        logic [15:0] r;
        logic        c;
        logic [2:0]  op, d, s0, s1;
        logic [15:0] old;

        // Reset with an instruction presented the whole time.
        opcode = 3'd0; rd = 3'd7; rs0 = 3'd1; rs1 = 3'd2; instr_valid = 1'b1;
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) preload(i[2:0], 16'h5A5A);
        @(negedge clk);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_rd0_addr", rd0_addr, 3'd0);
        check("rst_rd1_addr", rd1_addr, 3'd0);
        check("rst_wr_addr", wr_addr, 3'd0);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_flag_z", flag_z, 1'b0);
        check("rst_flag_c", flag_c, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1'b1);
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_wr_after_rst", wr_en, 1'b0);
        end
        check("rf7_untouched", rf[7], 16'h5A5A);

        // ADD wraps to zero with carry.
        preload(3'd1, 16'hFFFF); preload(3'd2, 16'h0001);
        push_exp(3'd3, 16'h0000, 1'b1); issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0); wait_wb(3);
        // SUB with borrow.
        preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
        push_exp(3'd4, 16'hFFFE, 1'b1); issue(3'd1, 3'd4, 3'd1, 3'd2, 1'b0); wait_wb(3);
        // SHL by 1 shifts out the MSB; SHR by 0 leaves value and clears carry.
        preload(3'd1, 16'h8001); preload(3'd2, 16'h0001);
        push_exp(3'd3, 16'h0002, 1'b1); issue(3'd5, 3'd3, 3'd1, 3'd2, 1'b0); wait_wb(3);
        preload(3'd2, 16'h0000);
        push_exp(3'd3, 16'h8001, 1'b0); issue(3'd6, 3'd3, 3'd1, 3'd2, 1'b0); wait_wb(3);
        // Logic ops.
        preload(3'd1, 16'hF0F0); preload(3'd2, 16'h0FF0);
        push_exp(3'd6, 16'h00F0, 1'b0); issue(3'd2, 3'd6, 3'd1, 3'd2, 1'b0); wait_wb(3);
        push_exp(3'd6, 16'hFFF0, 1'b0); issue(3'd3, 3'd6, 3'd1, 3'd2, 1'b0); wait_wb(3);
        push_exp(3'd0, 16'hFF00, 1'b0); issue(3'd4, 3'd0, 3'd1, 3'd2, 1'b0); wait_wb(3);
        // MUL: overflow into the upper half, then an in-range product.
        preload(3'd1, 16'h0100); preload(3'd2, 16'h0300);
        push_exp(3'd5, 16'h0000, 1'b1); issue(3'd7, 3'd5, 3'd1, 3'd2, 1'b0); wait_wb(18);
        preload(3'd1, 16'h00FF); preload(3'd2, 16'h00FF);
        push_exp(3'd5, 16'hFE01, 1'b0); issue(3'd7, 3'd5, 3'd1, 3'd2, 1'b0); wait_wb(18);

        // Random operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            preload(3'($urandom_range(0, 7)), 16'($urandom));
            preload(3'($urandom_range(0, 7)), 16'($urandom_range(0, 40)));
            op = 3'($urandom_range(0, 7));
            d  = 3'($urandom_range(0, 7));
            s0 = 3'($urandom_range(0, 7));
            s1 = 3'($urandom_range(0, 7));
            ref_op(op, rf[s0], rf[s1], r, c);
            push_exp(d, r, c);
            issue(op, d, s0, s1, 1'b0);
            wait_wb((op == 3'd7) ? 18 : 3);
        end

        // Back-to-back with instr_valid held: XOR must wait and see the new R5.
        preload(3'd1, 16'h1234); preload(3'd2, 16'h0101);
        push_exp(3'd5, 16'h1335, 1'b0);
        issue(3'd0, 3'd5, 3'd1, 3'd2, 1'b1);
        opcode = 3'd4; rd = 3'd6; rs0 = 3'd5; rs1 = 3'd5;
        wait_wb(3);
        push_exp(3'd6, 16'h0000, 1'b0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("b2b_rd0_addr", rd0_addr, 3'd5);
        wait_wb(3);
        check("b2b_r5", rf[5], 16'h1335);

        // Reset in cycle 8 of a MUL aborts with no write.
        preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
        old = rf[6];
        issue(3'd7, 3'd6, 3'd1, 3'd2, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", instr_ready, 1'b1);
        check("abort_flag_z", flag_z, 1'b0);
        check("abort_flag_c", flag_c, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("abort_no_write", wr_en, 1'b0);
        end
        check("abort_rf6", rf[6], old);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Sequential execute stage that sits directly downstream of the 8×16 register file and feeds its write port. It accepts one three-register instruction through a valid/ready handshake, drives the register file read addresses, captures both operands, and executes ALU, shift or multi-cycle multiply operations. It then writes the 16-bit result back through `wr_en`/`wr_addr`/`wr_data` and reports zero/carry flags.

## Interface
- `DATA_W`, 16, operand/result width; must match the register file data width.
- `ADDR_W`, 3, register address width; must match the register file address width.
- `clk` in 1: the single clock; every register in the block is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: an instruction is presented on `opcode`/`rd`/`rs0`/`rs1`.
- `instr_ready` out 1: the block can accept an instruction.
- `opcode` in 3: operation code; see Operation.
- `rd` in ADDR_W: destination register address.
- `rs0` in ADDR_W: source register address for operand A.
- `rs1` in ADDR_W: source register address for operand B.
- `rd0_addr` out ADDR_W: drives the register file read port 0 address.
- `rd1_addr` out ADDR_W: drives the register file read port 1 address.
- `rd0_data` in DATA_W: register file read port 0 data, combinational from `rd0_addr`.
- `rd1_data` in DATA_W: register file read port 1 data, combinational from `rd1_addr`.
- `wr_en` out 1: register file write enable, high for one cycle per instruction.
- `wr_addr` out ADDR_W: register file write address.
- `wr_data` out DATA_W: register file write data.
- `done` out 1: one-cycle pulse, coincident with `wr_en`.
- `flag_z` out 1: last result was zero; registered, updated at write-back.
- `flag_c` out 1: last carry, borrow or overflow indication; registered, updated at write-back.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: `instr_ready`=1. On `instr_valid`&`instr_ready`, latch `opcode`, `rd`, `rs0` and `rs1`, then go to READ.
- READ: `rd0_addr`=rs0 and `rd1_addr`=rs1, both registered outputs. Capture A=`rd0_data` and B=`rd1_data` at the end of this cycle. Go to EXEC.
- EXEC: single-cycle ops compute in one cycle and go to WB. MUL stays in EXEC for 16 cycles, then goes to WB.
- WB: `wr_en`=1, `wr_addr`=rd, `wr_data`=result, `done`=1, and flags are updated. Go to IDLE.
- `instr_ready` is 0 in READ, EXEC and WB. Instructions are not queued.
- Opcodes and results:
  - 0 ADD: A+B. `flag_c` = carry out of bit 15.
  - 1 SUB: A−B. `flag_c` = borrow (A<B, unsigned).
  - 2 AND, 3 OR, 4 XOR: `flag_c`=0.
  - 5 SHL: A<<B[3:0]. `flag_c` = last bit shifted out; 0 when the shift amount is 0.
  - 6 SHR: logical A>>B[3:0]. `flag_c` rule same as SHL.
  - 7 MUL: unsigned shift-add multiply. Result = product[15:0]; `flag_c` = (product[31:16]≠0).
- `flag_z` = (result==0) for every opcode. Arithmetic wraps modulo 2^16.
- Any `rd` may be written, including register 0. `rd` may equal `rs0` or `rs1`.
- Back-to-back read-after-write is safe without forwarding: the register file commits the write at the WB→IDLE edge, and the next READ occurs at least two cycles later.

## Timing
- Reset values: state=IDLE, `instr_ready`=1, `wr_en`=0, `done`=0, `rd0_addr`=`rd1_addr`=`wr_addr`=0, `wr_data`=0, `flag_z`=0, `flag_c`=0, internal operands=0.
- Call the acceptance edge E0. READ is the cycle after E0, EXEC the next, WB the next.
- Single-cycle op: `wr_en`/`done` are high in the third cycle after E0. `instr_ready` returns to 1 in the fourth cycle. Maximum throughput is 1 instruction per 4 cycles.
- MUL: `wr_en` is high in the 18th cycle after E0; `instr_ready` returns to 1 in the 19th.
- `instr_valid` while busy is ignored; the instruction is not latched.
- `rst` mid-operation aborts immediately and asynchronously: `wr_en` drops, no write occurs, flags clear, and the state returns to IDLE.
- Opcode, address and data inputs are sampled only at E0 (instruction fields) and at the end of READ (operand data).

## Structure
- Package `exec_pkg`:
  - `DATA_W`/`ADDR_W` defaults.
  - `opcode_e` enum: ADD, SUB, AND, OR, XOR, SHL, SHR, MUL = 0..7.
  - `state_e` enum: IDLE, READ, EXEC, WB.
  - `MUL_CYCLES`=16.
- Sub-module `mul16_seq`: radix-2 shift-add multiplier.
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `busy`, `product[31:0]`, `valid`.
  - `valid` pulses after 16 cycles.
  - `exec_unit` stays in EXEC until `valid`.
- The top level holds the FSM, instruction latch, single-cycle ALU/shifter and flag registers.

## Test plan
- Reset with `instr_valid`=1 held: no `wr_en` during or after reset; `instr_ready`=1 once `rst` falls; all outputs at reset values.
- R1=0xFFFF, R2=0x0001, ADD rd=3: `wr_en` in the 3rd cycle after acceptance with `wr_addr`=3, `wr_data`=0x0000, `flag_z`=1, `flag_c`=1.
- R1=0x0003, R2=0x0005, SUB rd=4: `wr_data`=0xFFFE, `flag_c`=1, `flag_z`=0.
- SHL with A=0x8001, B=0x0001: `wr_data`=0x0002, `flag_c`=1. SHR with A=0x8001, B=0x0000: `wr_data`=0x8001, `flag_c`=0.
- MUL with 0x0100×0x0300: `wr_data`=0x0000, `flag_c`=1, `flag_z`=1, with `wr_en` in the 18th cycle. 0x00FF×0x00FF: `wr_data`=0xFE01, `flag_c`=0.
- Back-to-back ADD R5=R1+R2 then XOR R6=R5^R5 with `instr_valid` held high: the second is accepted only when `instr_ready` rises, and it writes R6=0x0000 using the updated R5. Asserting `rst` in cycle 8 of a MUL produces no write.
